// File: rtl/ex_fu_scheduler.sv
// EX-stage functional-unit scheduler: one-hot result select, mul/div launch and tracking, stall request.
// Optional divider watchdog and div_timeout port when EX_SCHED_WATCHDOG_EN is defined.
//
// state    | meaning
// IDLE     | accepting issue; single-cycle ops complete here
// MUL_WAIT | multiplier in flight, counter = cycles left
// DIV_WAIT | divider in flight, waiting for div_done
module ex_fu_scheduler #(
  parameter int MUL_LATENCY     = 2,
  parameter int DIV_LATENCY_MAX = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [4:0] issue_class,
  input  logic       flush,
  input  logic       div_done,
  output logic       mul_start,
  output logic       div_start,
  output logic       div_cancel,
  output logic [4:0] select,
  output logic       result_valid,
  output logic       stall_req,
  output logic       illegal_op
`ifdef EX_SCHED_WATCHDOG_EN
  ,
  output logic       div_timeout
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_WAIT = 2'd1;
  localparam logic [1:0] DIV_WAIT = 2'd2;

  localparam int CNT_TOP = (DIV_LATENCY_MAX > MUL_LATENCY) ? DIV_LATENCY_MAX : MUL_LATENCY;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [4:0] SEL_MUL = 5'b00010;
  localparam logic [4:0] SEL_DIV = 5'b00100;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timeout;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mul_start    = 1'b0;
    div_start    = 1'b0;
    div_cancel   = 1'b0;
    select       = 5'b0;
    result_valid = 1'b0;
    stall_req    = 1'b0;
    illegal_op   = 1'b0;
    timeout      = 1'b0;
    if (!rst_n) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (flush) begin
      // Flush drops any completion landing in the same cycle.
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      div_cancel = (state == DIV_WAIT);
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            if (!$onehot(issue_class)) begin
              illegal_op = 1'b1;
            end else if (issue_class[1]) begin
              mul_start = 1'b1;
              stall_req = 1'b1;
              cnt_nxt   = CW'(MUL_LATENCY - 1);
              state_nxt = MUL_WAIT;
            end else if (issue_class[2]) begin
              div_start = 1'b1;
              stall_req = 1'b1;
`ifdef EX_SCHED_WATCHDOG_EN
              cnt_nxt   = CW'(DIV_LATENCY_MAX - 1);
`else
              cnt_nxt   = '0;
`endif
              state_nxt = DIV_WAIT;
            end else begin
              select       = issue_class;
              result_valid = 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt == '0) begin
            select       = SEL_MUL;
            result_valid = 1'b1;
            state_nxt    = IDLE;
          end else begin
            stall_req = 1'b1;
            cnt_nxt   = cnt - CW'(1);
          end
        end
        DIV_WAIT: begin
          if (div_done) begin
            select       = SEL_DIV;
            result_valid = 1'b1;
            state_nxt    = IDLE;
            cnt_nxt      = '0;
          end else begin
`ifdef EX_SCHED_WATCHDOG_EN
            // Watchdog expiry returns a zero result so the pipeline can move on.
            if (cnt == '0) begin
              timeout      = 1'b1;
              div_cancel   = 1'b1;
              result_valid = 1'b1;
              state_nxt    = IDLE;
            end else begin
              stall_req = 1'b1;
              cnt_nxt   = cnt - CW'(1);
            end
`else
            stall_req = 1'b1;
`endif
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef EX_SCHED_WATCHDOG_EN
  assign div_timeout = timeout;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ex_fu_scheduler.sv
// Self-checking bench for ex_fu_scheduler: directed test-plan steps then random traffic,
// all checked against an operation-age reference model.
module tb_ex_fu_scheduler;

  localparam int MUL_LAT = 2;
  localparam int DIV_MAX = 40;

  logic       clk = 1'b0;
  logic       rst_n, issue_valid, flush, div_done;
  logic [4:0] issue_class;
  logic       mul_start, div_start, div_cancel, result_valid, stall_req, illegal_op;
  logic [4:0] select;
`ifdef EX_SCHED_WATCHDOG_EN
  logic       div_timeout;
`endif

  always #5 clk = ~clk;

  ex_fu_scheduler #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY_MAX(DIV_MAX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_class(issue_class),
    .flush(flush),
    .div_done(div_done),
    .mul_start(mul_start),
    .div_start(div_start),
    .div_cancel(div_cancel),
    .select(select),
    .result_valid(result_valid),
    .stall_req(stall_req),
    .illegal_op(illegal_op)
`ifdef EX_SCHED_WATCHDOG_EN
    ,
    .div_timeout(div_timeout)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: which op is outstanding and how many cycles since it launched.
  int m_busy = 0;  // 0 none, 1 mul, 2 div
  int m_age  = 0;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at vector %0d: observed %b expected %b", tag, vectors, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [4:0] cls,
                      input logic fl, input logic dd);
    logic [4:0] e_sel;
    logic e_rv, e_stall, e_ms, e_ds, e_dc, e_ill, e_to;
    int nb, na;
    rst_n = r; issue_valid = iv; issue_class = cls; flush = fl; div_done = dd;
    @(negedge clk);
    e_sel = 5'b0; e_rv = 0; e_stall = 0; e_ms = 0; e_ds = 0; e_dc = 0; e_ill = 0; e_to = 0;
    nb = m_busy; na = m_age + 1;
    if (!r) begin
      nb = 0;
    end else if (fl) begin
      nb = 0;
      e_dc = (m_busy == 2);
    end else if (m_busy == 0) begin
      if (iv) begin
        if ($countones(cls) != 1) e_ill = 1;
        else if (cls == 5'b00010) begin e_ms = 1; e_stall = 1; nb = 1; na = 1; end
        else if (cls == 5'b00100) begin e_ds = 1; e_stall = 1; nb = 2; na = 1; end
        else begin e_sel = cls; e_rv = 1; end
      end
    end else if (m_busy == 1) begin
      if (m_age == MUL_LAT) begin e_sel = 5'b00010; e_rv = 1; nb = 0; end
      else e_stall = 1;
    end else begin
      if (dd) begin e_sel = 5'b00100; e_rv = 1; nb = 0; end
`ifdef EX_SCHED_WATCHDOG_EN
      else if (m_age == DIV_MAX) begin e_to = 1; e_dc = 1; e_rv = 1; nb = 0; end
`endif
      else e_stall = 1;
    end
    vectors++;
    chk("select",       select,             e_sel);
    chk("result_valid", {4'b0, result_valid}, {4'b0, e_rv});
    chk("stall_req",    {4'b0, stall_req},    {4'b0, e_stall});
    chk("mul_start",    {4'b0, mul_start},    {4'b0, e_ms});
    chk("div_start",    {4'b0, div_start},    {4'b0, e_ds});
    chk("div_cancel",   {4'b0, div_cancel},   {4'b0, e_dc});
    chk("illegal_op",   {4'b0, illegal_op},   {4'b0, e_ill});
`ifdef EX_SCHED_WATCHDOG_EN
    chk("div_timeout",  {4'b0, div_timeout},  {4'b0, e_to});
`else
    e_to = 0;
`endif
    @(posedge clk);
    m_busy = nb;
    m_age  = na;
    #1;
  endtask

  initial begin
    logic [4:0] cls;
    int k;
    rst_n = 0; issue_valid = 0; issue_class = 0; flush = 0; div_done = 0;
    @(posedge clk); #1;

    // reset and single-cycle / illegal classes
    step(0, 0, 5'b0, 0, 0);
    step(0, 1, 5'b00001, 0, 0);
    step(1, 0, 5'b0, 0, 0);
    step(1, 1, 5'b00001, 0, 0);
    step(1, 1, 5'b00011, 0, 0);
    step(1, 1, 5'b00000, 0, 0);
    step(1, 1, 5'b11000, 0, 0);

    // mul then logic op
    step(1, 1, 5'b00010, 0, 0);
    step(1, 1, 5'b00001, 0, 0);
    step(1, 0, 5'b0, 0, 0);
    step(1, 1, 5'b01000, 0, 0);

    // div with coincident div_done ignored, completion at T+10
    step(1, 1, 5'b00100, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 1, 5'b00001, 0, 0);
    step(1, 0, 5'b0, 0, 1);
    step(1, 1, 5'b10000, 0, 0);

    // div flushed at T+5, later div_done has no effect
    step(1, 1, 5'b00100, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 5'b0, 0, 0);
    step(1, 0, 5'b0, 1, 0);
    step(1, 0, 5'b0, 0, 1);
    step(1, 1, 5'b10000, 0, 0);

    // flush coincident with mul completion, new mul next cycle
    step(1, 1, 5'b00010, 0, 0);
    step(1, 0, 5'b0, 0, 0);
    step(1, 0, 5'b0, 1, 0);
    step(1, 1, 5'b00010, 0, 0);
    step(1, 0, 5'b0, 0, 0);
    step(1, 0, 5'b0, 0, 0);

    // flush coincident with div_done, reset mid-div
    step(1, 1, 5'b00100, 0, 0);
    step(1, 0, 5'b0, 1, 1);
    step(1, 1, 5'b00100, 0, 0);
    step(1, 0, 5'b0, 0, 0);
    step(0, 0, 5'b0, 0, 0);
    step(1, 1, 5'b00001, 0, 0);

    // long divide: watchdog fires at T+40 when enabled, otherwise keeps stalling
    step(1, 1, 5'b00100, 0, 0);
    for (int i = 0; i < 45; i++) step(1, 0, 5'b0, 0, 0);
    step(1, 0, 5'b0, 0, 1);
    step(1, 0, 5'b0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5) cls = 5'(1 << k);
      else cls = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), cls,
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
